song_sequencer: RTL and testbench

//  Parametrised song reader. Walks the song ROM for the selected song and issues

---
 rtl/song_sequencer.sv | 148 ++++++++++++++
 tb/tb_song_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song reader: walks the ROM for the selected song, issues notes, counts rest beats, flags end of song.
// Latency: new_note pulses 2 cycles after FETCH (1-cycle ROM read + registered decode); one note per 3 cycles.
// Backpressure: play=0 freezes position and partial rests; SONG_LOOP_EN makes DONE restart the song.
module song_sequencer #(
  parameter int SONG_W      = 2,
  parameter int NOTE_ADDR_W = 5,
  parameter int REST_W      = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_W-1:0]             song,
  input  logic                          beat,
  output logic [SONG_W+NOTE_ADDR_W-1:0] rom_addr,
  input  logic [15:0]                   rom_dout,
  output logic                          new_note,
  output logic [5:0]                    note,
  output logic [5:0]                    duration,
  output logic [2:0]                    metadata,
  output logic                          song_done,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_REST, S_ADV, S_DONE
  } state_t;

  localparam logic [REST_W-1:0]      REST_ONE = 1;
  localparam logic [NOTE_ADDR_W-1:0] ADDR_ONE = 1;

  state_t                   state, state_n;
  logic [SONG_W-1:0]        song_q;
  logic [NOTE_ADDR_W-1:0]   note_addr;
  logic [REST_W-1:0]        rest_cnt;
  logic [REST_W-1:0]        rest_tgt;

  logic load_song, clr_addr, inc_addr, load_note, load_rest, inc_rest, clr_rest;

  logic       w_rest;
  logic [5:0] w_note;
  logic [5:0] w_dur;
  logic [2:0] w_meta;

  assign w_rest   = rom_dout[15];
  assign w_note   = rom_dout[14:9];
  assign w_dur    = rom_dout[8:3];
  assign w_meta   = rom_dout[2:0];
  assign rom_addr = {song_q, note_addr};
  assign busy     = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_n   = state;
    load_song = 1'b0;
    clr_addr  = 1'b0;
    inc_addr  = 1'b0;
    load_note = 1'b0;
    load_rest = 1'b0;
    inc_rest  = 1'b0;
    clr_rest  = 1'b0;
    // A song change while running restarts the new song and beats every other transition.
    if (busy && play && (song != song_q)) begin
      state_n   = S_FETCH;
      load_song = 1'b1;
      clr_addr  = 1'b1;
      clr_rest  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (play) begin
            load_song = 1'b1;
            clr_addr  = 1'b1;
            state_n   = S_FETCH;
          end
        end
        S_FETCH: if (play) state_n = S_WAIT;
        S_WAIT: begin
          if (play) begin
            if (!w_rest) begin
              load_note = 1'b1;
              state_n   = S_ADV;
            end else if (w_note != 6'd0) begin
              load_rest = 1'b1;
              state_n   = S_REST;
            end else begin
              state_n   = S_DONE;
            end
          end
        end
        S_REST: begin
          if (play && beat) begin
            inc_rest = 1'b1;
            if (rest_cnt + REST_ONE == rest_tgt) state_n = S_ADV;
          end
        end
        S_ADV: begin
          if (play) begin
            if (note_addr == '1) begin
              state_n = S_DONE;
            end else begin
              inc_addr = 1'b1;
              state_n  = S_FETCH;
            end
          end
        end
        S_DONE: begin
`ifdef SONG_LOOP_EN
          clr_addr = 1'b1;
          state_n  = S_FETCH;
`else
          if (!play) state_n = S_IDLE;
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      song_q    <= '0;
      note_addr <= '0;
      rest_cnt  <= '0;
      rest_tgt  <= '0;
      new_note  <= 1'b0;
      note      <= '0;
      duration  <= '0;
      metadata  <= '0;
      song_done <= 1'b0;
    end else begin
      state     <= state_n;
      new_note  <= load_note;
      song_done <= (state_n == S_DONE) && (state != S_DONE);
      if (load_song) song_q <= song;
      if (clr_addr)      note_addr <= '0;
      else if (inc_addr) note_addr <= note_addr + ADDR_ONE;
      if (clr_rest || load_rest) rest_cnt <= '0;
      else if (inc_rest)         rest_cnt <= rest_cnt + REST_ONE;
      if (load_rest) rest_tgt <= REST_W'(w_note);
      if (load_note) begin
        note     <= w_note;
        duration <= w_dur;
        metadata <= w_meta;
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed and randomized checks of song_sequencer against a word-level ROM walk model.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset, play, beat;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        new_note, song_done, busy;
  logic [5:0]  note, duration;
  logic [2:0]  metadata;

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .new_note(new_note),
    .note(note), .duration(duration), .metadata(metadata),
    .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:127];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  int          stamp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (new_note) begin
      got_q.push_back({note, duration, metadata});
      stamp_q.push_back(cyc);
    end
    if (song_done) n_done++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk_note(input int n, input int d, input int m);
    logic [5:0] nn, dd;
    logic [2:0] mm;
    nn = 6'(n); dd = 6'(d); mm = 3'(m);
    return {1'b0, nn, dd, mm};
  endfunction

  function automatic logic [15:0] mk_rest(input int n);
    logic [5:0] nn;
    nn = 6'(n);
    return {1'b1, nn, 9'd0};
  endfunction

  localparam logic [15:0] END_W = 16'h8000;

  // Expected note sequence: read the song's words in order, keep notes, skip rests, stop at end marker or after 32 words.
  function automatic void build_exp(input int s);
    logic [15:0] w;
    exp_q.delete();
    for (int a = 0; a < 32; a++) begin
      w = rom[s*32 + a];
      if (!w[15]) exp_q.push_back(w[14:0]);
      else if (w[14:9] == 6'd0) break;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic give_beat();
    beat = 1'b1;
    step(1);
    beat = 1'b0;
  endtask

  task automatic wait_note(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (got_q.size() <= base && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(got_q.size() > base), 32'd1);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (n_done <= base && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(n_done > base), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; beat = 1'b0;
    step(2);
    reset = 1'b0;
    got_q.delete(); stamp_q.delete(); n_done = 0;
  endtask

  task automatic cmp_notes(input string tag, input int s);
    build_exp(s);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = END_W;
    rom[0]  = mk_note(20, 12, 3); rom[1] = mk_rest(2); rom[2] = END_W;
    rom[32] = mk_note(1, 2, 3); rom[33] = mk_note(4, 5, 6); rom[34] = mk_note(7, 1, 2); rom[35] = END_W;
    rom[64] = mk_rest(5); rom[65] = mk_note(7, 7, 7); rom[66] = END_W;
    for (int i = 0; i < 32; i++) rom[96 + i] = mk_note($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7));
    song = 2'd0;

    // Reset state
    do_reset();
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_outs", 32'({new_note, note, duration, metadata, song_done, busy}), 0);

    // Note, 2-beat rest, end marker
    play = 1'b1;
    wait_note(0, 20, "t1_note_seen");
    chk("t1_note", 32'({note, duration, metadata}), 32'({6'd20, 6'd12, 3'd3}));
    step(6);
    chk("t1_rest_busy", 32'(busy), 1);
    give_beat();
    step(6);
    chk("t1_rest_hold", 32'({busy, 8'(n_done)}), 32'({1'b1, 8'd0}));
    give_beat();
    wait_done(0, 20, "t1_done_seen");
    chk("t1_idle_busy", 32'(busy), 0);
    cmp_notes("t1", 0);
`ifndef SONG_LOOP_EN
    step(10);
    chk("t1_done_hold", 32'({busy, 8'(n_done), 8'(got_q.size())}), 32'({1'b0, 8'd1, 8'd1}));
    play = 1'b0;
    step(2);
    play = 1'b1;
    wait_note(1, 20, "t1_restart");
    chk("t1_restart_note", 32'(note), 20);
`else
    wait_note(1, 20, "t1_loop_note");
`endif
    // Reset in the middle of a rest
    step(6);
    reset = 1'b1;
    step(1);
    chk("rst_in_rest", 32'({rom_addr, new_note, note, duration, metadata, song_done, busy}), 0);
    reset = 1'b0;

    // Back-to-back notes, 3 cycles apart
    do_reset();
    song = 2'd1; play = 1'b1;
    wait_done(0, 40, "t2_done_seen");
    cmp_notes("t2", 1);
    if (stamp_q.size() >= 3) begin
      chk("t2_gap1", 32'(stamp_q[1] - stamp_q[0]), 3);
      chk("t2_gap2", 32'(stamp_q[2] - stamp_q[1]), 3);
    end

    // Pause during a 5-beat rest
    do_reset();
    song = 2'd2; play = 1'b1;
    step(6);
    give_beat(); give_beat();
    play = 1'b0;
    step(1);
    repeat (4) begin give_beat(); step(1); end
    chk("t3_paused", 32'({rom_addr, busy, 8'(got_q.size()), 8'(n_done)}), 32'({7'd64, 1'b1, 8'd0, 8'd0}));
    play = 1'b1;
    step(1);
    give_beat(); give_beat();
    step(6);
    chk("t3_not_yet", 32'(got_q.size()), 0);
    give_beat();
    wait_note(0, 10, "t3_note_seen");
    chk("t3_note", 32'(note), 7);

    // Song change mid-rest
    do_reset();
    song = 2'd0; play = 1'b1;
    wait_note(0, 20, "t4_note_seen");
    step(6);
    song = 2'd2;
    step(1);
    chk("t4_rom_addr", 32'(rom_addr), 64);
    step(3);
    chk("t4_no_done", 32'({busy, 8'(n_done)}), 32'({1'b1, 8'd0}));

    // 32 words, no end marker
    do_reset();
    song = 2'd3; play = 1'b1;
    wait_done(0, 200, "t5_done_seen");
    cmp_notes("t5", 3);
    chk("t5_final_addr", 32'(rom_addr), 127);
    step(1);
    chk("t5_done_once", 32'(n_done), 1);

`ifdef SONG_LOOP_EN
    do_reset();
    rom[32] = mk_note(9, 9, 1); rom[33] = mk_note(10, 2, 2); rom[34] = END_W;
    song = 2'd1; play = 1'b1;
    wait_done(2, 100, "loop_passes");
    chk("loop_notes", 32'(got_q.size() >= 6), 1);
`endif

    // Randomized songs with random beats
    for (int it = 0; it < 5; it++) begin
      int len, k;
      len = $urandom_range(1, 31);
      for (int i = 0; i < 32; i++) begin
        if (i == len) rom[32 + i] = END_W;
        else if ($urandom_range(0, 2) == 0) rom[32 + i] = mk_rest($urandom_range(1, 3));
        else rom[32 + i] = mk_note($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7));
      end
      do_reset();
      song = 2'd1; play = 1'b1;
      k = 0;
      while (n_done == 0 && k < 3000) begin
        beat = ($urandom_range(0, 3) == 0);
        step(1);
        k++;
      end
      beat = 1'b0;
`ifndef SONG_LOOP_EN
      chk("rnd_done", 32'(n_done), 1);
      cmp_notes("rnd", 1);
`else
      chk("rnd_done", 32'(n_done > 0), 1);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
